moore_fsm: RTL and testbench
============================

MOORE_FSM -- requirements
Module: moore_fsm

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 The block SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-003 clk_i  input  1  system clock; all state updates on rising edge.
REQ-004 rst_i  input  1  asynchronous active-low reset.
REQ-005 next_i  input  1  serial data bit, sampled on each rising clk_i edge.
REQ-006 out_o  output  1  detection flag; 1 only while the FSM is in state S4.

Function
REQ-007 The block SHALL be a Moore machine detecting the serial sequence 1,0,1,1 on next_i, with overlapping matches allowed.
REQ-008 States SHALL be:
- S0: idle, nothing matched.
- S1: "1" matched.
- S2: "10" matched.
- S3: "101" matched.
- S4: "1011" matched.
REQ-009 Encoding SHALL be 3-bit binary: S0=000, S1=001, S2=010, S3=011, S4=100.
REQ-010 Transitions, sampled on rising clk_i (next_i=0 / next_i=1):
- S0 -> S0 / S1
- S1 -> S2 / S1
- S2 -> S0 / S3
- S3 -> S2 / S4
- S4 -> S2 / S1
REQ-011 Unused codes 101, 110 and 111 SHALL go to S0 on the next rising edge; out_o SHALL be 0 while in any of them.
REQ-012 out_o SHALL be a combinational decode of the state register only (out_o = 1 iff state == S4), with no combinational path from next_i.
REQ-013 Latency: out_o SHALL rise in the same clock cycle that the state register enters S4, i.e. immediately after the rising edge that samples the final "1" of the sequence.
REQ-014 out_o SHALL stay high for exactly one clock cycle per detection, since S4 is never re-entered directly.
REQ-015 The state register SHALL be a single signal named state_moore of the package state type, so benches can probe and force it hierarchically.
REQ-016 State values SHALL be named S0_MOORE..S4_MOORE.
REQ-017 A forced or externally deposited state value SHALL be followed by normal transitions from that value on the next edge.

Reset
REQ-018 While rst_i=0, state_moore SHALL be S0 and out_o SHALL be 0, independent of clk_i.
REQ-019 Assertion of rst_i mid-sequence, including while in S4, SHALL abort the partial match immediately and drop out_o to 0 without waiting for a clock edge.
REQ-020 After rst_i deasserts, the first rising edge SHALL evaluate from S0.
REQ-021 There SHALL be no other reset or clear source.

Structure
REQ-022 A shared package moore_fsm_pkg SHALL hold:
- typedef enum logic [2:0] state_t, with members S0_MOORE..S4_MOORE at the REQ-009 encodings;
- localparam STATE_W = 3.
REQ-023 The RTL SHALL be split into three processes: a sequential state register, combinational next-state logic with a default branch, and combinational output decode.
REQ-024 No sub-module SHALL be used; the block is a single module.

Verification
REQ-025 Reset: hold rst_i=0 for 2 cycles with next_i toggling -> state=S0, out_o=0 throughout; release rst_i -> state stays S0 while next_i=0.
REQ-026 Basic detect: next_i = 1,0,1,1 on successive edges -> states S1,S2,S3,S4; out_o=1 for exactly the cycle in S4.
REQ-027 Overlap: continue with 0,1,1 -> states S2,S3,S4; out_o pulses high a second time. Then apply 1 -> S1, out_o=0.
REQ-028 Fallbacks:
- from S1 apply 1 -> S1;
- then 0,0 -> S2, S0;
- then 0 -> S0;
- from S3 apply 0 -> S2.
out_o=0 throughout.
REQ-029 Async reset mid-detect: with state=S4 and out_o=1, drop rst_i between clock edges -> out_o=0 and state=S0 before the next edge.
REQ-030 Illegal state: force state_moore=3'b110 and release -> out_o=0; the next rising edge yields S0 regardless of next_i.

Source files
------------

// File: rtl/moore_fsm_pkg.sv
// moore_fsm_pkg
// Shared definitions for the 1011 sequence-detecting Moore machine.
//   STATE_W : width of the state register
//   state_t : state encoding, S0_MOORE..S4_MOORE = number of pattern bits
//             matched so far (000..100); codes 101..111 are unused
package moore_fsm_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S0_MOORE = 3'b000,
        S1_MOORE = 3'b001,
        S2_MOORE = 3'b010,
        S3_MOORE = 3'b011,
        S4_MOORE = 3'b100
    } state_t;

endpackage : moore_fsm_pkg

// File: rtl/moore_fsm.sv
// moore_fsm
// Moore machine detecting the serial pattern 1,0,1,1 on next_i with
// overlapping matches. out_o pulses for one cycle per detection.
// Ports:
//   clk_i  : system clock, state advances on the rising edge
//   rst_i  : asynchronous active-low reset, forces S0 immediately
//   next_i : serial data bit sampled on each rising clk_i edge
//   out_o  : detection flag, high only while the state is S4
module moore_fsm
    import moore_fsm_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic next_i,
    output logic out_o
);

    // Kept as one named variable so benches can probe or force it.
    state_t state_moore;
    state_t state_d;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_moore <= S0_MOORE;
        end else begin
            state_moore <= state_d;
        end
    end

    // Fallback targets keep the longest suffix that is still a prefix of
    // 1011, which is what makes overlapping detections work.
    always_comb begin
        state_d = S0_MOORE;
        case (state_moore)
            S0_MOORE: state_d = next_i ? S1_MOORE : S0_MOORE;
            S1_MOORE: state_d = next_i ? S1_MOORE : S2_MOORE;
            S2_MOORE: state_d = next_i ? S3_MOORE : S0_MOORE;
            S3_MOORE: state_d = next_i ? S4_MOORE : S2_MOORE;
            S4_MOORE: state_d = next_i ? S1_MOORE : S2_MOORE;
            // Unused codes recover to idle regardless of the input.
            default:  state_d = S0_MOORE;
        endcase
    end

    // Pure state decode: no path from next_i to out_o.
    always_comb begin
        out_o = (state_moore == S4_MOORE);
    end

endmodule : moore_fsm

// File: tb/tb_moore_fsm.sv
// tb_moore_fsm
// Scoreboard bench for moore_fsm. The driver applies one bit per cycle and
// pushes the expected {state, out} for the following rising edge; the
// monitor pops and compares one entry per cycle. The reference derives the
// expected state as the longest suffix of the bits seen since the last
// reset that is also a prefix of 1,0,1,1.
module tb_moore_fsm;

    logic clk_i  = 1'b0;
    logic rst_i  = 1'b0;
    logic next_i = 1'b0;
    logic out_o;

    int vectors    = 0;
    int miscompares = 0;

    logic [3:0] exp_q[$];   // {state[2:0], out}
    bit         hist[$];    // bits sampled since last reset / recovery

    moore_fsm dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .next_i (next_i),
        .out_o  (out_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [3:0] model_expect();
        bit pat[4];
        int best;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1; pat[3] = 1'b1;
        best = 0;
        for (int k = 1; k <= 4; k++) begin
            if (k <= hist.size()) begin
                bit ok;
                ok = 1'b1;
                for (int j = 0; j < k; j++) begin
                    if (hist[hist.size() - k + j] != pat[j]) ok = 1'b0;
                end
                if (ok) best = k;
            end
        end
        return {best[2:0], (best == 4)};
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got state=%b out=%b, expected state=%b out=%b",
                     name, act[3:1], act[0], exp[3:1], exp[0]);
        end
    endtask

    function automatic logic [3:0] dut_now();
        logic [2:0] s;
        s = dut.state_moore;
        return {s, out_o};
    endfunction

    // One cycle of stimulus: drive reset level and data bit at the falling
    // edge, record what the next rising edge should produce.
    task automatic step(input bit b, input bit r);
        @(negedge clk_i);
        rst_i  = r;
        next_i = b;
        if (!r) hist.delete();
        else begin
            hist.push_back(b);
            if (hist.size() > 8) void'(hist.pop_front());
        end
        exp_q.push_back(model_expect());
    endtask

    // Monitor: one expectation is consumed per rising edge.
    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            if (exp_q.size() > 0) begin
                logic [3:0] e;
                e = exp_q.pop_front();
                check("edge", dut_now(), e);
            end
        end
    end

    initial begin
        #1;
        check("reset_init", dut_now(), 4'b000_0);

        // Reset held with data toggling, then release with zeros.
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);

        // Basic detect, overlap, fallbacks.
        step(1'b1, 1'b1); step(1'b0, 1'b1); step(1'b1, 1'b1); step(1'b1, 1'b1);
        step(1'b0, 1'b1); step(1'b1, 1'b1); step(1'b1, 1'b1);
        step(1'b1, 1'b1); step(1'b1, 1'b1);
        step(1'b0, 1'b1); step(1'b0, 1'b1); step(1'b0, 1'b1);
        step(1'b1, 1'b1); step(1'b0, 1'b1); step(1'b1, 1'b1); step(1'b0, 1'b1);

        // Reach S4 then assert reset between edges.
        step(1'b1, 1'b1); step(1'b0, 1'b1); step(1'b1, 1'b1); step(1'b1, 1'b1);
        @(posedge clk_i);
        #3;
        check("pre_async_s4", dut_now(), 4'b100_1);
        rst_i = 1'b0;
        #1;
        check("async_reset", dut_now(), 4'b000_0);
        hist.delete();
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);

        // Deposit an unused code and confirm recovery to idle.
        for (int n = 0; n < 3; n++) begin
            @(negedge clk_i);
            force dut.state_moore = moore_fsm_pkg::state_t'(3'b110 + n[2:0] - 3'd1);
            #1;
            release dut.state_moore;
            check("illegal_out", {3'b000, out_o}, 4'b000_0);
            next_i = $urandom_range(0, 1);
            hist.delete();
            exp_q.push_back(4'b000_0);
        end

        // Randomized run with occasional reset pulses.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 1, $urandom_range(0, 49) != 0);
        end

        // Drain the scoreboard with a bounded wait.
        for (int w = 0; w < 5 && exp_q.size() > 0; w++) @(posedge clk_i);
        #2;
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_moore_fsm
